// File: rtl/decoder_pkg.sv
// Shared constants for the 2-to-4 address-select decoder.
//   D_WIDTH    : number of decoded lines
//   D_INACTIVE : all lines deasserted (active-low), used for reset and disable
package decoder_pkg;

    localparam int D_WIDTH = 4;

    localparam logic [0:D_WIDTH-1] D_INACTIVE = 4'b1111;

endpackage

// File: rtl/decoder_2x4_core.sv
// Combinational 2-to-4 decode core built only from NOT/NAND gate primitives.
// Ports:
//   D_n[0:3] out : active-low decoded lines (D_n[0] selected by AB=00)
//   A        in  : select MSB
//   B        in  : select LSB
//   enable   in  : active-low enable; 1 forces all lines high
module decoder_2x4_core
    import decoder_pkg::*;
(
    output logic [0:D_WIDTH-1] D_n,
    input  logic               A,
    input  logic               B,
    input  logic               enable
);

    logic a_n;
    logic b_n;
    logic en;

    not u_not_a  (a_n, A);
    not u_not_b  (b_n, B);
    not u_not_en (en, enable);

    // Each 3-input NAND pulls its line low only when enable is asserted
    // and the select bits match that line's index.
    nand u_nand_0 (D_n[0], a_n, b_n, en);
    nand u_nand_1 (D_n[1], a_n, B,   en);
    nand u_nand_2 (D_n[2], A,   b_n, en);
    nand u_nand_3 (D_n[3], A,   B,   en);

endmodule

// File: rtl/decoder_2to4_gates.sv
// Registered 2-to-4 line decoder with active-low enable and active-low outputs.
// The gate-level core's output is captured in a register so NAND-tree hazards
// never reach the downstream select lines; latency is one clock.
// Ports:
//   clk      in  : sole clock, rising edge
//   rst      in  : synchronous active-high reset, forces D to all-inactive
//   A        in  : select MSB
//   B        in  : select LSB
//   enable   in  : active-low enable
//   D[0:3]   out : registered active-low decoded lines
module decoder_2to4_gates
    import decoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               B,
    input  logic               enable,
    output logic [0:D_WIDTH-1] D
);

    logic [0:D_WIDTH-1] d_next;

    decoder_2x4_core u_core (
        .D_n    (d_next),
        .A      (A),
        .B      (B),
        .enable (enable)
    );

    // Reset takes priority over any decode on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            D <= D_INACTIVE;
        end else begin
            D <= d_next;
        end
    end

endmodule

// File: tb/tb_decoder_2to4_gates.sv
module tb_decoder_2to4_gates;

    logic       clk = 1'b0;
    logic       rst;
    logic       A;
    logic       B;
    logic       enable;
    logic [0:3] D;

    int checks   = 0;
    int failures = 0;

    decoder_2to4_gates dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .enable (enable),
        .D      (D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        logic [0:3] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [0:3] act, input logic [0:3] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: D=%b expected %b", name, act, exp);
        end
    endtask

    // Independent reference: clear the bit indexed by {A,B} unless disabled.
    function automatic logic [0:3] model(input logic r, input logic a, input logic b, input logic en);
        logic [0:3] v;
        logic [1:0] idx;
        v = 4'b1111;
        idx = {a, b};
        if (!r && !en) v[idx] = 1'b0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pr, pa, pb, pe;
        logic [0:3] exp;
        logic [0:3] inv;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'b0111};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 4'b1011};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'b1101};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'b1110};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 4'b1111};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 4'b1111};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 4'b1111};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 4'b1111};

        // Reset held two cycles with a decode-worthy input present.
        rst = 1'b1; enable = 1'b0; A = 1'b1; B = 1'b1;
        @(negedge clk);
        check("reset_cycle1", D, 4'b1111);
        @(negedge clk);
        check("reset_cycle2", D, 4'b1111);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", D, 4'b1110);

        // Sweep and disable patterns, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            A = vecs[i].a; B = vecs[i].b; enable = vecs[i].en;
            @(negedge clk);
            check($sformatf("vec%0d", i), D, vecs[i].exp);
        end

        // Latency: input change just after an edge is not seen until the next edge.
        A = 1'b0; B = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("lat_base", D, 4'b0111);
        @(posedge clk);
        #1;
        A = 1'b1; B = 1'b0;
        #2;
        check("lat_hold", D, 4'b0111);
        @(posedge clk);
        #1;
        check("lat_update", D, 4'b1101);
        @(negedge clk);

        // Mid-run one-cycle reset pulse.
        A = 1'b0; B = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("mid_ab01", D, 4'b1011);
        A = 1'b1; B = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mid_reset", D, 4'b1111);
        rst = 1'b0;
        @(negedge clk);
        check("mid_resume", D, 4'b1101);

        // Random run against the delayed model, with occasional reset.
        for (int i = 0; i < 300; i++) begin
            pr = ($urandom_range(0, 15) == 0);
            pa = $urandom_range(0, 1);
            pb = $urandom_range(0, 1);
            pe = ($urandom_range(0, 3) == 0);
            rst = pr; A = pa; B = pb; enable = pe;
            @(negedge clk);
            exp = model(pr, pa, pb, pe);
            check("rand_value", D, exp);
            inv = ~D;
            checks++;
            if ($countones(inv) > 1) begin
                failures++;
                $display("FAIL rand_onecold: D=%b has more than one low line", D);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
